// File: rtl/fixed_div.sv
// Iterative sign-magnitude fixed-point divider c = a / b, one quotient bit per cycle.
// Restoring division of {|a|, FWL zeros} by |b|, with saturation and divide-by-zero flags.
module fixed_div #(
   parameter int WL  = 32,
   parameter int IWL = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WL-1:0] a,
   input  logic [WL-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WL-1:0] c,
   output logic          ovf,
   output logic          dz
);

   localparam int FWL = WL - IWL;
   localparam int Q   = WL - 1 + FWL;
   localparam int CW  = $clog2(Q + 1);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready is high only in IDLE and out_valid only in DONE, and
   // c/ovf/dz stay frozen while out_valid is high and out_ready is low.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic          sign;
   logic [Q-1:0]  num;
   logic [WL-2:0] den;
   logic [WL-1:0] rem;
   logic [Q-2:0]  quo;
   logic [CW-1:0] cnt;

   logic          accept;
   logic          den_zero_in;
   logic [WL-1:0] rem_shift;
   logic          take;
   logic [WL-1:0] rem_next;
   logic [Q-1:0]  quo_next;
   logic          last;
   logic          quo_ovf;

   assign accept      = in_valid && in_ready;
   assign den_zero_in = (b[WL-2:0] == '0);

   // The remainder always stays below den, so its top bit is zero; folding it
   // into the compare keeps the step exact even if that ever changed.
   assign rem_shift = {rem[WL-2:0], num[Q-1]};
   assign take      = rem[WL-1] | (rem_shift >= {1'b0, den});
   assign rem_next  = take ? (rem_shift - {1'b0, den}) : rem_shift;
   assign quo_next  = {quo, take};
   assign last      = (cnt == CW'(Q - 1));
   assign quo_ovf   = |quo_next[Q-1:WL-1];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = den_zero_in ? DONE : CALC;
            end
         end
         CALC: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath and registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign <= 1'b0;
         num  <= '0;
         den  <= '0;
         rem  <= '0;
         quo  <= '0;
         cnt  <= '0;
         c    <= '0;
         ovf  <= 1'b0;
         dz   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign <= a[WL-1] ^ b[WL-1];
                  num  <= {a[WL-2:0], {FWL{1'b0}}};
                  den  <= b[WL-2:0];
                  rem  <= '0;
                  quo  <= '0;
                  cnt  <= '0;
                  ovf  <= 1'b0;
                  if (den_zero_in) begin
                     c  <= {a[WL-1] ^ b[WL-1], {(WL-1){1'b1}}};
                     dz <= 1'b1;
                  end else begin
                     c  <= '0;
                     dz <= 1'b0;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               quo <= quo_next[Q-2:0];
               num <= {num[Q-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (last) begin
                  c   <= {sign, quo_ovf ? {(WL-1){1'b1}} : quo_next[WL-2:0]};
                  ovf <= quo_ovf;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_div.sv
// Directed bench for fixed_div at WL=32, IWL=8 (Q=55) with hand-computed quotients.
module tb_fixed_div;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] c;
   logic        ovf;
   logic        dz;

   int errors = 0;
   int checks = 0;

   fixed_div #(.WL(32), .IWL(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .ovf       (ovf),
      .dz        (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents operands, returns cycles from the accept cycle to out_valid (1 = next sample).
   task automatic start_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
      int n;
      @(negedge clk);
      a = av;
      b = bv;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic finish_op(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_iready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_c, input logic exp_ovf, input logic exp_dz,
                          input int exp_lat);
      int lat;
      start_op(av, bv, lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_c"}, c, exp_c);
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      check({tag, "_dz"}, {31'd0, dz}, {31'd0, exp_dz});
      finish_op(tag);
   endtask

   initial begin
      int lat;
      logic seen_valid;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_c", c, 32'h0000_0000);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_dz", {31'd0, dz}, 32'd0);

      // 6.0 / 2.0 = 3.0
      run_div("basic", 32'h0600_0000, 32'h0200_0000, 32'h0300_0000, 1'b0, 1'b0, 56);
      // 100.0 / 0.5 saturates
      run_div("ovf", 32'h6400_0000, 32'h0080_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 56);
      // 1.0 / 3.0 truncates; ovf from the previous op must be cleared
      run_div("third", 32'h0100_0000, 32'h0300_0000, 32'h0055_5555, 1'b0, 1'b0, 56);
      // Negative-zero divisor counts as zero
      run_div("divz", 32'h0100_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
      // -1.0 / 4.0 = -0.25; dz from the previous op must be cleared
      run_div("neg", 32'h8100_0000, 32'h0400_0000, 32'h8040_0000, 1'b0, 1'b0, 56);
      // -0 / 1.0 keeps the sign: negative zero
      run_div("negzero", 32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 1'b0, 1'b0, 56);
      // Positive zero divisor, -2.0 / 0 -> sign set
      run_div("divz_pos", 32'h8200_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);

      // Backpressure: 10.0 / 4.0 = 2.5, held while new operands are offered
      start_op(32'h0A00_0000, 32'h0400_0000, lat);
      check("bp_lat", 32'(lat), 32'd56);
      a = 32'h7F00_0000;
      b = 32'h0000_0001;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_c_hold", c, 32'h0280_0000);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      finish_op("bp");
      // -3.0 / 1.5 = -2.0 accepted right after the release
      run_div("bp_next", 32'h8300_0000, 32'h0180_0000, 32'h8200_0000, 1'b0, 1'b0, 56);

      // Reset 20 cycles into CALC
      @(negedge clk);
      a = 32'h0600_0000;
      b = 32'h0200_0000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_c", c, 32'h0000_0000);
      check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
      check("mid_rst_dz", {31'd0, dz}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check("mid_rst_no_output", {31'd0, seen_valid}, 32'd0);

      // Divider still usable after the abandoned op
      run_div("post_rst", 32'h0600_0000, 32'h0200_0000, 32'h0300_0000, 1'b0, 1'b0, 56);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fixed_div.md
Name: fixed_div

Overview:
- Iterative sign-magnitude fixed-point divider: c = a / b.
- Uses the same WL/IWL operand format as the datapath's fixed-point multiplier, and serves as its inverse operation.
- Sits in the datapath wherever normalisation or scaling divides are needed, e.g. softmax denominators and attention weight scaling.
- Produces one quotient bit per cycle behind a valid/ready handshake on both input and output.

Parameters:
- WL, 32, total word length: 1 sign bit plus WL-1 magnitude bits.
- IWL, 8, integer word length including the sign bit. FWL = WL-IWL fractional bits; legal range 1 <= IWL < WL.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands a and b are valid.
- in_ready, output, 1, divider can accept operands.
- a, input, WL, dividend (sign-magnitude).
- b, input, WL, divisor (sign-magnitude).
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- c, output, WL, quotient (sign-magnitude).
- ovf, output, 1, quotient magnitude saturated.
- dz, output, 1, divide by zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; c=0; ovf=0; dz=0; internal registers cleared. Any operation in flight is abandoned; nothing is emitted afterwards.
- States are IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, register three values: sign = a[WL-1]^b[WL-1]; N = {a[WL-2:0], FWL zeros}, a value of Q = WL-1+FWL bits; D = b[WL-2:0].
  - If D==0, go to DONE with dz=1.
  - Otherwise clear the remainder and the iteration counter, and go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Exactly Q cycles of restoring division, MSB first. Each cycle: rem = {rem, next N bit}; if rem >= D then rem -= D and shift in quotient bit 1, else shift in quotient bit 0.
  - Remainder register is WL bits wide; no carries are lost.
  - After the Q-th cycle, go to DONE.
- Result rules:
  - Quotient truncates toward zero.
  - If any of the upper FWL quotient bits is 1: c = {sign, all ones}, ovf=1.
  - Otherwise: c = {sign, quotient[WL-2:0]}, ovf=0.
  - Divide by zero: c = {sign, all ones}, dz=1, ovf=0.
  - Sign is always the XOR of the input signs, even for a zero magnitude. This matches the multiplier convention; negative zero is permitted.
- DONE:
  - out_valid=1, in_ready=0.
  - c, ovf and dz are registered and held stable while out_ready=0.
  - On out_ready=1, go to IDLE. out_valid drops the next cycle; no new operand is accepted in the same cycle.
- Latency (from the accept edge to the out_valid=1 edge): Q+1 cycles for a normal divide (56 at the defaults); 1 cycle for divide by zero.
- Throughput: one divide per Q+2 cycles minimum.
- Negative-zero divisor (b = 1 followed by zeros) is treated as zero.
- a, b and in_valid are ignored outside IDLE.
- flags are valid only while out_valid=1 and are cleared on entry to CALC.

Test Plan (WL=32, IWL=8, so FWL=24 and Q=55):
- Reset: rst_n low, then release -> in_ready=1, out_valid=0, c=0, ovf=0, dz=0.
- Basic divide: a=0x06000000, b=0x02000000 (6.0/2.0) -> c=0x03000000, ovf=0, dz=0; out_valid asserted 56 cycles after the accept edge.
- Sign and truncation: a=0x81000000, b=0x04000000 (-1.0/4.0) -> c=0x80400000. a=0x01000000, b=0x03000000 -> c=0x00555555.
- Overflow: a=0x64000000, b=0x00800000 (100.0/0.5) -> c=0x7FFFFFFF, ovf=1.
- Divide by zero: a=0x01000000, b=0x80000000 -> c=0xFFFFFFFF, dz=1, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> c stable, in_ready=0. Then pulse out_ready -> IDLE, and the next operand is accepted.
- Reset mid-op: assert rst_n=0 at cycle 20 of CALC -> outputs return to reset values immediately; no out_valid is produced afterwards.
